// File: rtl/wbuart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package  : wbuart_pkg                                                      |
// | Purpose  : Shared types and constants for the wbuart receive/transmit path |
// |            (receiver state encoding, frame sizes, parity encodings and a   |
// |            parity check helper).                                           |
// | Ports    : none (package)                                                  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package wbuart_pkg;

  // Receiver state encoding; the FSM copies these into fixed-width constants.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_t;

  localparam int MIN_FRAME_SIZE = 8;   // data field width
  localparam int MAX_FRAME_SIZE = 11;  // data + parity + two stop bits

  localparam logic PARITY_EVEN = 1'b0;
  localparam logic PARITY_ODD  = 1'b1;

  // Returns 1 when XOR(data bits) ^ received parity bit differs from the
  // selected sense (0 for even, 1 for odd).
  function automatic logic parity_error(input logic data_xor,
                                        input logic parity_bit,
                                        input logic odd);
    return (data_xor ^ parity_bit) != odd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wbuart_rx_deserializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : wbuart_rx_deserializer_if                                      |
// | Purpose   : Groups the receiver configuration, serial line and decoded     |
// |             frame signals between the register block and the receiver.     |
// | Signals   : cr_clk_div_i[15:0], cr_ds_i, cr_s_i, cr_p_i[1:0], uart_rx_i    |
// |             (toward receiver); frame_o[FRAME_W-1:0], parity_err_o,         |
// |             frame_err_o, output_valid_o (from receiver).                   |
// | Modports  : master = register block / line driver, slave = receiver        |
// | Revision  : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
interface wbuart_rx_deserializer_if #(
  parameter int FRAME_W = 11
);
  logic [15:0]        cr_clk_div_i;
  logic               cr_ds_i;
  logic               cr_s_i;
  logic [1:0]         cr_p_i;
  logic               uart_rx_i;
  logic [FRAME_W-1:0] frame_o;
  logic               parity_err_o;
  logic               frame_err_o;
  logic               output_valid_o;

  modport master (
    output cr_clk_div_i, cr_ds_i, cr_s_i, cr_p_i, uart_rx_i,
    input  frame_o, parity_err_o, frame_err_o, output_valid_o
  );

  modport slave (
    input  cr_clk_div_i, cr_ds_i, cr_s_i, cr_p_i, uart_rx_i,
    output frame_o, parity_err_o, frame_err_o, output_valid_o
  );
endinterface
`default_nettype wire

// File: rtl/wbuart_baud_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wbuart_baud_counter                                             |
// | Purpose  : Loadable down-counter producing a one-cycle tick at terminal    |
// |            count; paces bit sampling (and bit emission on the TX side).    |
// | Ports    : clk_i, rst_i      clock / async active-high reset              |
// |            load              load load_value into the counter             |
// |            load_value[15:0]  cycles until the next tick                   |
// |            enable            count while high                             |
// |            tick              high in the cycle the count reaches 1        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wbuart_baud_counter (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  input  wire logic        load,
  input  wire logic [15:0] load_value,
  input  wire logic        enable,
  output logic             tick
);

  logic [15:0] count;

  // A load of N makes tick fire in the N-th cycle after the load edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != 16'd0)) begin
      count <= count - 16'd1;
    end
  end

  assign tick = enable && (count == 16'd1);

endmodule
`default_nettype wire

// File: rtl/wbuart_rx_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : wbuart_rx_deserializer                                          |
// | Purpose  : UART receive path: synchronises the serial line, detects start  |
// |            edges, samples each bit at mid-bit, assembles and checks a      |
// |            frame (7/8 data, optional parity, 1/2 stop) and pulses it out.  |
// | Ports    : clk_i   system clock                                            |
// |            rst_i   asynchronous active-high reset                          |
// |            bus     slave side of wbuart_rx_deserializer_if (config in,     |
// |                    uart_rx_i in, frame/error/valid out)                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module wbuart_rx_deserializer #(
  parameter int MAX_FRAME_SIZE = 11,
  parameter int SYNC_STAGES    = 2
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  wbuart_rx_deserializer_if.slave bus
);
  import wbuart_pkg::*;

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;
  localparam logic [2:0] ST_DONE   = DONE;

  logic [SYNC_STAGES-1:0]    sync_ff;
  logic                      rx_s;
  logic                      prev_rx;
  logic [2:0]                state;
  logic [2:0]                bit_idx;
  logic                      stop_idx;
  logic                      stop0;
  logic                      ferr_acc;
  logic                      par_acc;
  logic                      par_bit;
  logic [MIN_FRAME_SIZE-1:0] data_sh;
  logic [MAX_FRAME_SIZE-1:0] frame_q;
  logic                      perr_q;
  logic                      ferr_q;

  logic        rx_enabled;
  logic        start_edge;
  logic        load_start;
  logic        sampling;
  logic        tick;
  logic        cnt_load;
  logic [15:0] clk_div_eff;
  logic [15:0] cnt_value;
  logic [2:0]  last_data;
  logic        last_stop;
  logic [10:0] frame_next;
  logic        ferr_next;
  logic        perr_next;

  assign rx_s = sync_ff[SYNC_STAGES-1];

  // A divider of 1 cannot give a mid-bit sample point, so it runs as 2.
  assign rx_enabled  = (bus.cr_clk_div_i != 16'd0);
  assign clk_div_eff = (bus.cr_clk_div_i == 16'd1) ? 16'd2 : bus.cr_clk_div_i;

  assign start_edge = prev_rx & ~rx_s;
  assign load_start = (state == ST_IDLE) && start_edge && rx_enabled;
  assign sampling   = rx_enabled &&
                      ((state == ST_START) || (state == ST_DATA) ||
                       (state == ST_PARITY) || (state == ST_STOP));

  // First expiry lands half a bit after the edge; every later one a full bit on.
  assign cnt_load  = load_start || tick;
  assign cnt_value = load_start ? (clk_div_eff >> 1) : clk_div_eff;

  wbuart_baud_counter u_baud (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load       (cnt_load),
    .load_value (cnt_value),
    .enable     (sampling),
    .tick       (tick)
  );

  assign last_data = bus.cr_ds_i ? 3'd6 : 3'd7;
  assign last_stop = ~bus.cr_s_i | stop_idx;

  // Frame as it stands once the final stop bit is sampled. With one stop bit
  // the sample lands in bit 9 and bit 10 reads as an implicit 1.
  always_comb begin
    frame_next = {(bus.cr_s_i ? rx_s : 1'b1),
                  (bus.cr_s_i ? stop0 : rx_s),
                  par_bit,
                  data_sh};
    ferr_next  = ferr_acc | ~rx_s;
    perr_next  = bus.cr_p_i[1] &
                 parity_error(par_acc, par_bit, bus.cr_p_i[0] == PARITY_ODD);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_ff  <= '1;
      prev_rx  <= 1'b1;
      state    <= ST_IDLE;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      stop0    <= 1'b1;
      ferr_acc <= 1'b0;
      par_acc  <= 1'b0;
      par_bit  <= 1'b0;
      data_sh  <= '0;
      frame_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.uart_rx_i};
      prev_rx <= rx_s;

      if (!rx_enabled) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_edge) state <= ST_START;
          end

          ST_START: begin
            if (tick) begin
              if (rx_s) begin
                // Line went back high before mid-start: treat as a glitch.
                state <= ST_IDLE;
              end else begin
                state    <= ST_DATA;
                bit_idx  <= '0;
                stop_idx <= 1'b0;
                stop0    <= 1'b1;
                ferr_acc <= 1'b0;
                par_acc  <= 1'b0;
                par_bit  <= 1'b0;
                data_sh  <= '0;
              end
            end
          end

          ST_DATA: begin
            if (tick) begin
              data_sh[bit_idx] <= rx_s;
              par_acc          <= par_acc ^ rx_s;
              bit_idx          <= bit_idx + 3'd1;
              if (bit_idx == last_data) begin
                state <= bus.cr_p_i[1] ? ST_PARITY : ST_STOP;
              end
            end
          end

          ST_PARITY: begin
            if (tick) begin
              par_bit <= rx_s;
              state   <= ST_STOP;
            end
          end

          ST_STOP: begin
            if (tick) begin
              if (last_stop) begin
                frame_q <= MAX_FRAME_SIZE'(frame_next);
                ferr_q  <= ferr_next;
                perr_q  <= perr_next;
                state   <= ST_DONE;
              end else begin
                stop0    <= rx_s;
                ferr_acc <= ferr_next;
                stop_idx <= 1'b1;
              end
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
          end

          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.frame_o        = frame_q;
  assign bus.parity_err_o   = perr_q;
  assign bus.frame_err_o    = ferr_q;
  assign bus.output_valid_o = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_wbuart_rx_deserializer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module   : tb_wbuart_rx_deserializer                                       |
// | Purpose  : Self-checking bench for wbuart_rx_deserializer: a table of      |
// |            directed frames plus hand-written corner-case sequences.        |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_wbuart_rx_deserializer;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  wbuart_rx_deserializer_if #(.FRAME_W(11)) bus ();

  wbuart_rx_deserializer #(
    .MAX_FRAME_SIZE (11),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct {
    logic [10:0] frame;
    logic        pe;
    logic        fe;
    int          cyc;
  } cap_t;

  cap_t caps[$];

  // Every valid pulse is logged with the cycle it was seen in.
  always @(negedge clk_i) begin
    if (bus.output_valid_o === 1'b1) begin
      cap_t c;
      c.frame = bus.frame_o;
      c.pe    = bus.parity_err_o;
      c.fe    = bus.frame_err_o;
      c.cyc   = cyc;
      caps.push_back(c);
    end
  end

  typedef struct {
    logic [15:0] div;
    int          bit_len;
    logic        ds;
    logic        s;
    logic [1:0]  p;
    logic [7:0]  data;
    logic        par_val;
    logic [1:0]  stop_val;   // [0] first stop bit, [1] second
    logic [10:0] exp_frame;
    logic        exp_pe;
    logic        exp_fe;
    int          exp_lat;    // start-edge drive cycle to valid cycle
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int len);
    bus.uart_rx_i = b;
    idle(len);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input logic par_en,
                            input logic par_val, input int nstop, input logic [1:0] stop_val,
                            input int bit_len, output int start_cyc);
    start_cyc = cyc;
    drive_bit(1'b0, bit_len);
    for (int i = 0; i < nbits; i++) drive_bit(data[i], bit_len);
    if (par_en) drive_bit(par_val, bit_len);
    for (int i = 0; i < nstop; i++) drive_bit(stop_val[i], bit_len);
  endtask

  task automatic wait_pulses(input int n, input int budget, input string name);
    int k;
    k = 0;
    while ((caps.size() < n) && (k < budget)) begin
      idle(1);
      k++;
    end
    check({name, " pulse before timeout"}, 32'(caps.size() >= n), 32'd1);
  endtask

  task automatic config_rx(input logic [15:0] div, input logic ds, input logic s, input logic [1:0] p);
    bus.cr_clk_div_i = div;
    bus.cr_ds_i      = ds;
    bus.cr_s_i       = s;
    bus.cr_p_i       = p;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   st;
    cap_t c;

    //             div    len ds    s     p      data   par   stop   frame    pe    fe    lat
    vecs[0] = '{16'd16, 16, 1'b0, 1'b0, 2'b00, 8'h55, 1'b0, 2'b11, 11'h655, 1'b0, 1'b0, 155};
    vecs[1] = '{16'd16, 16, 1'b1, 1'b1, 2'b11, 8'h41, 1'b1, 2'b11, 11'h741, 1'b0, 1'b0, 171};
    vecs[2] = '{16'd16, 16, 1'b1, 1'b1, 2'b11, 8'h41, 1'b0, 2'b11, 11'h641, 1'b1, 1'b0, 171};
    vecs[3] = '{16'd10, 10, 1'b0, 1'b0, 2'b00, 8'h5A, 1'b0, 2'b10, 11'h45A, 1'b0, 1'b1,  98};
    vecs[4] = '{16'd4,   4, 1'b0, 1'b0, 2'b10, 8'h3C, 1'b0, 2'b11, 11'h63C, 1'b0, 1'b0,  45};
    vecs[5] = '{16'd1,   2, 1'b0, 1'b0, 2'b11, 8'h3C, 1'b0, 2'b11, 11'h63C, 1'b1, 1'b0,  24};
    vecs[6] = '{16'd16, 16, 1'b1, 1'b0, 2'b00, 8'hFF, 1'b0, 2'b11, 11'h67F, 1'b0, 1'b0, 139};
    vecs[7] = '{16'd8,   8, 1'b0, 1'b1, 2'b00, 8'hC3, 1'b0, 2'b01, 11'h2C3, 1'b0, 1'b1,  87};

    config_rx(16'd16, 1'b0, 1'b0, 2'b00);
    bus.uart_rx_i = 1'b1;
    rst_i = 1'b1;
    idle(3);
    check("reset frame_o",        32'(bus.frame_o),        32'h0);
    check("reset parity_err_o",   32'(bus.parity_err_o),   32'h0);
    check("reset frame_err_o",    32'(bus.frame_err_o),    32'h0);
    check("reset output_valid_o", 32'(bus.output_valid_o), 32'h0);
    rst_i = 1'b0;
    idle(5);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      config_rx(vecs[v].div, vecs[v].ds, vecs[v].s, vecs[v].p);
      idle(2);
      caps.delete();
      send_frame(vecs[v].data, vecs[v].ds ? 7 : 8, vecs[v].p[1], vecs[v].par_val,
                 vecs[v].s ? 2 : 1, vecs[v].stop_val, vecs[v].bit_len, st);
      bus.uart_rx_i = 1'b1;
      wait_pulses(1, 100, $sformatf("v%0d", v));
      idle(8);
      check($sformatf("v%0d pulse count", v), 32'(caps.size()), 32'd1);
      if (caps.size() > 0) begin
        c = caps[0];
        check($sformatf("v%0d frame_o", v),      32'(c.frame),    32'(vecs[v].exp_frame));
        check($sformatf("v%0d parity_err_o", v), 32'(c.pe),       32'(vecs[v].exp_pe));
        check($sformatf("v%0d frame_err_o", v),  32'(c.fe),       32'(vecs[v].exp_fe));
        check($sformatf("v%0d latency", v),      32'(c.cyc - st), 32'(vecs[v].exp_lat));
      end
      check($sformatf("v%0d frame_o held", v), 32'(bus.frame_o), 32'(vecs[v].exp_frame));
    end

    // Stop bit 0 with the line then held low: one frame, then silence until re-armed.
    config_rx(16'd10, 1'b0, 1'b0, 2'b00);
    caps.delete();
    send_frame(8'h00, 8, 1'b0, 1'b0, 1, 2'b00, 10, st);
    wait_pulses(1, 60, "break");
    if (caps.size() > 0) begin
      check("break frame_o",     32'(caps[0].frame), 32'h400);
      check("break frame_err_o", 32'(caps[0].fe),    32'd1);
    end
    idle(200);
    check("break held low no pulse", 32'(caps.size()), 32'd1);
    bus.uart_rx_i = 1'b1;
    idle(30);
    check("break released no pulse", 32'(caps.size()), 32'd1);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 2'b11, 10, st);
    wait_pulses(2, 60, "after break");
    if (caps.size() > 1) begin
      check("after break frame_o",     32'(caps[1].frame), 32'h65A);
      check("after break frame_err_o", 32'(caps[1].fe),    32'd0);
    end

    // Three-cycle low glitch, then a real frame.
    config_rx(16'd16, 1'b0, 1'b0, 2'b00);
    idle(5);
    caps.delete();
    bus.uart_rx_i = 1'b0;
    idle(3);
    bus.uart_rx_i = 1'b1;
    idle(40);
    check("glitch no pulse", 32'(caps.size()), 32'd0);
    send_frame(8'hA3, 8, 1'b0, 1'b0, 1, 2'b11, 16, st);
    wait_pulses(1, 100, "post glitch");
    if (caps.size() > 0) check("post glitch frame_o", 32'(caps[0].frame), 32'h6A3);

    // Back-to-back frames with no idle gap.
    config_rx(16'd8, 1'b0, 1'b0, 2'b00);
    idle(5);
    caps.delete();
    send_frame(8'h00, 8, 1'b0, 1'b0, 1, 2'b11, 8, st);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1, 2'b11, 8, st);
    bus.uart_rx_i = 1'b1;
    wait_pulses(2, 60, "b2b");
    idle(10);
    check("b2b pulse count", 32'(caps.size()), 32'd2);
    if (caps.size() > 1) begin
      check("b2b first frame_o",  32'(caps[0].frame), 32'h600);
      check("b2b second frame_o", 32'(caps[1].frame), 32'h6FF);
    end

    // Reset in the middle of the data bits clears outputs at once.
    caps.delete();
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 8);
    rst_i = 1'b1;
    #1;
    check("async reset frame_o",        32'(bus.frame_o),        32'h0);
    check("async reset output_valid_o", 32'(bus.output_valid_o), 32'h0);
    check("async reset frame_err_o",    32'(bus.frame_err_o),    32'h0);
    idle(1);
    rst_i = 1'b0;
    bus.uart_rx_i = 1'b1;
    idle(20);
    check("aborted frame no pulse", 32'(caps.size()), 32'd0);
    send_frame(8'h96, 8, 1'b0, 1'b0, 1, 2'b11, 8, st);
    wait_pulses(1, 60, "post reset");
    if (caps.size() > 0) check("post reset frame_o", 32'(caps[0].frame), 32'h696);

    // Disabled receiver ignores line activity; then 8E1 at divider 4.
    config_rx(16'd0, 1'b0, 1'b0, 2'b00);
    idle(5);
    caps.delete();
    for (int i = 0; i < 60; i++) begin
      bus.uart_rx_i = ~bus.uart_rx_i;
      idle(3);
    end
    bus.uart_rx_i = 1'b1;
    idle(20);
    check("disabled no pulse", 32'(caps.size()), 32'd0);
    config_rx(16'd4, 1'b0, 1'b0, 2'b10);
    idle(5);
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1, 2'b11, 4, st);
    wait_pulses(1, 40, "8E1");
    if (caps.size() > 0) begin
      check("8E1 frame_o",      32'(caps[0].frame), 32'h63C);
      check("8E1 parity_err_o", 32'(caps[0].pe),    32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
